// File: rtl/npu_mem_pkg.sv
// Shared types and helpers for the NPU/CPU data-memory arbiter.
package npu_mem_pkg;

    // Identifies which master a memory access belongs to.
    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_NPU = 1'b1
    } owner_t;

    localparam int DEFAULT_ADDR_W = 32;
    localparam int DEFAULT_DATA_W = 32;

    // Width of the NPU starvation counter: must hold 0..max_stall, never narrower than 1 bit.
    function automatic int starve_cnt_w(input int max_stall);
        return (max_stall < 1) ? 1 : $clog2(max_stall + 1);
    endfunction

endpackage

// File: rtl/npu_mem_arbiter_rd_return.sv
// Read-return path: remembers who issued the read in the previous cycle and
// steers the 1-cycle-latency memory data to that master only.
module npu_mem_arbiter_rd_return
    import npu_mem_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W
) (
    input  logic              clk,
    input  logic              srst,
    input  logic              rd_fire,
    input  owner_t            rd_owner,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] npu_rdata,
    output logic              npu_rvalid
);

    logic              rd_pending_reg;
    owner_t            owner_reg;
    logic [1:0]        rvalid_vec;
    logic [DATA_W-1:0] rdata_vec [2];

    // Tag register: one outstanding read at most, refreshed every cycle for full-rate reads.
    always_ff @(posedge clk) begin
        if (srst) begin
            rd_pending_reg <= 1'b0;
            owner_reg      <= OWN_CPU;
        end else begin
            rd_pending_reg <= rd_fire;
            if (rd_fire) begin
                owner_reg <= rd_owner;
            end
        end
    end

    // Per-master demux; index 0 is the CPU, index 1 the NPU (matches owner_t encoding).
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_ret
            logic [DATA_W-1:0] rdata_hold_reg;

            // A reset landing on the return cycle aborts the in-flight read.
            assign rvalid_vec[gi] = rd_pending_reg & ~srst & (owner_reg == owner_t'(1'(gi)));
            assign rdata_vec[gi]  = rvalid_vec[gi] ? mem_rdata : rdata_hold_reg;

            // Keep the last delivered word so the non-owner's rdata stays stable.
            always_ff @(posedge clk) begin
                if (srst) begin
                    rdata_hold_reg <= '0;
                end else if (rvalid_vec[gi]) begin
                    rdata_hold_reg <= mem_rdata;
                end
            end
        end
    endgenerate

    assign cpu_rvalid = rvalid_vec[0];
    assign cpu_rdata  = rdata_vec[0];
    assign npu_rvalid = rvalid_vec[1];
    assign npu_rdata  = rdata_vec[1];

endmodule

// File: rtl/npu_mem_arbiter.sv
// Single data-memory port arbiter: CPU has fixed priority, the NPU wins a
// conflict once it has been denied MAX_STALL consecutive cycles.
module npu_mem_arbiter
    import npu_mem_pkg::*;
#(
    parameter int ADDR_W    = DEFAULT_ADDR_W,
    parameter int DATA_W    = DEFAULT_DATA_W,
    parameter int MAX_STALL = 4,
    parameter int CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_rd,
    input  logic              cpu_wr,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wd,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_rvalid,
    output logic              cpu_stall,
    input  logic              npu_rd,
    input  logic              npu_wr,
    input  logic [ADDR_W-1:0] npu_addr,
    input  logic [DATA_W-1:0] npu_wd,
    output logic [DATA_W-1:0] npu_rdata,
    output logic              npu_rvalid,
    output logic              race_haz,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wd,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              err_both,
    output logic [CNT_W-1:0]  conflict_cnt
);

    localparam int              SC_W        = starve_cnt_w(MAX_STALL);
    localparam logic [SC_W-1:0] STALL_LIMIT = SC_W'(MAX_STALL);

    logic             cpu_req;
    logic             npu_req;
    logic             npu_wins;
    logic             grant_cpu;
    logic             grant_npu;
    owner_t           rd_owner;
    logic [SC_W-1:0]  starve_cnt_reg;
    logic [SC_W-1:0]  starve_cnt_next;
    logic [CNT_W-1:0] conflict_cnt_reg;
    logic [CNT_W-1:0] conflict_cnt_next;
    logic             err_both_reg;
    logic             err_both_next;

    assign cpu_req  = cpu_rd | cpu_wr;
    assign npu_req  = npu_rd | npu_wr;
    // With MAX_STALL = 0 the counter is pinned at 0, so the NPU always wins.
    assign npu_wins = (starve_cnt_reg == STALL_LIMIT);

    // Same-cycle grant; everything is denied while reset is held.
    always_comb begin
        grant_cpu = 1'b0;
        grant_npu = 1'b0;
        if (!rst) begin
            if (cpu_req && (!npu_req || !npu_wins)) begin
                grant_cpu = 1'b1;
            end else if (npu_req) begin
                grant_npu = 1'b1;
            end
        end
    end

    assign cpu_stall = cpu_req & ~grant_cpu;
    assign race_haz  = npu_req & ~grant_npu;

    // Memory port mux; rd together with wr is issued as a write only.
    always_comb begin
        mem_rd   = 1'b0;
        mem_wr   = 1'b0;
        mem_addr = '0;
        mem_wd   = '0;
        if (grant_cpu) begin
            mem_rd   = cpu_rd & ~cpu_wr;
            mem_wr   = cpu_wr;
            mem_addr = cpu_addr;
            mem_wd   = cpu_wd;
        end else if (grant_npu) begin
            mem_rd   = npu_rd & ~npu_wr;
            mem_wr   = npu_wr;
            mem_addr = npu_addr;
            mem_wd   = npu_wd;
        end
    end

    // Next-state for starvation counter, conflict statistics and the sticky error flag.
    always_comb begin
        starve_cnt_next   = starve_cnt_reg;
        conflict_cnt_next = conflict_cnt_reg;
        err_both_next     = err_both_reg | (cpu_rd & cpu_wr) | (npu_rd & npu_wr);
        if (!npu_req || grant_npu) begin
            starve_cnt_next = '0;
        end else if (race_haz && (starve_cnt_reg != STALL_LIMIT)) begin
            starve_cnt_next = starve_cnt_reg + 1'b1;
        end
        if (cpu_req && npu_req && !(&conflict_cnt_reg)) begin
            conflict_cnt_next = conflict_cnt_reg + 1'b1;
        end
    end

    // Arbiter state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt_reg   <= '0;
            conflict_cnt_reg <= '0;
            err_both_reg     <= 1'b0;
        end else begin
            starve_cnt_reg   <= starve_cnt_next;
            conflict_cnt_reg <= conflict_cnt_next;
            err_both_reg     <= err_both_next;
        end
    end

    assign err_both     = err_both_reg;
    assign conflict_cnt = conflict_cnt_reg;
    assign rd_owner     = grant_npu ? OWN_NPU : OWN_CPU;

    npu_mem_arbiter_rd_return #(
        .DATA_W (DATA_W)
    ) u_rd_return (
        .clk        (clk),
        .srst       (rst),
        .rd_fire    (mem_rd),
        .rd_owner   (rd_owner),
        .mem_rdata  (mem_rdata),
        .cpu_rdata  (cpu_rdata),
        .cpu_rvalid (cpu_rvalid),
        .npu_rdata  (npu_rdata),
        .npu_rvalid (npu_rvalid)
    );

endmodule

// File: tb/tb_npu_mem_arbiter.sv
// Scoreboard bench for npu_mem_arbiter: stimulus pushes expected memory
// accesses and read returns, a negedge monitor pops and compares them.
module tb_npu_mem_arbiter;

    typedef struct packed {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wd;
    } mem_exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    // Main instance (MAX_STALL = 4)
    logic        cpu_rd = 1'b0, cpu_wr = 1'b0, npu_rd = 1'b0, npu_wr = 1'b0;
    logic [31:0] cpu_addr = '0, cpu_wd = '0, npu_addr = '0, npu_wd = '0;
    logic [31:0] mem_rdata = '0;
    logic [31:0] cpu_rdata, npu_rdata, mem_addr, mem_wd;
    logic        cpu_rvalid, npu_rvalid, cpu_stall, race_haz, mem_rd, mem_wr, err_both;
    logic [15:0] conflict_cnt;

    // Second instance (MAX_STALL = 0)
    logic        z_cpu_rd = 1'b0, z_cpu_wr = 1'b0, z_npu_rd = 1'b0, z_npu_wr = 1'b0;
    logic [31:0] z_cpu_addr = '0, z_cpu_wd = '0, z_npu_addr = '0, z_npu_wd = '0;
    logic [31:0] z_mem_rdata = '0;
    logic [31:0] z_cpu_rdata, z_npu_rdata, z_mem_addr, z_mem_wd;
    logic        z_cpu_rvalid, z_npu_rvalid, z_cpu_stall, z_race_haz, z_mem_rd, z_mem_wr, z_err_both;
    logic [15:0] z_conflict_cnt;

    logic [31:0] tb_mem [0:255];
    mem_exp_t    mem_q [$];
    logic [31:0] cpu_q [$];
    logic [31:0] npu_q [$];
    int          total = 0;
    int          bad   = 0;

    always #5 clk = ~clk;

    npu_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_STALL(4), .CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wd(cpu_wd),
        .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid), .cpu_stall(cpu_stall),
        .npu_rd(npu_rd), .npu_wr(npu_wr), .npu_addr(npu_addr), .npu_wd(npu_wd),
        .npu_rdata(npu_rdata), .npu_rvalid(npu_rvalid), .race_haz(race_haz),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wd(mem_wd),
        .mem_rdata(mem_rdata), .err_both(err_both), .conflict_cnt(conflict_cnt)
    );

    npu_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_STALL(0), .CNT_W(16)) dut0 (
        .clk(clk), .rst(rst),
        .cpu_rd(z_cpu_rd), .cpu_wr(z_cpu_wr), .cpu_addr(z_cpu_addr), .cpu_wd(z_cpu_wd),
        .cpu_rdata(z_cpu_rdata), .cpu_rvalid(z_cpu_rvalid), .cpu_stall(z_cpu_stall),
        .npu_rd(z_npu_rd), .npu_wr(z_npu_wr), .npu_addr(z_npu_addr), .npu_wd(z_npu_wd),
        .npu_rdata(z_npu_rdata), .npu_rvalid(z_npu_rvalid), .race_haz(z_race_haz),
        .mem_rd(z_mem_rd), .mem_wr(z_mem_wr), .mem_addr(z_mem_addr), .mem_wd(z_mem_wd),
        .mem_rdata(z_mem_rdata), .err_both(z_err_both), .conflict_cnt(z_conflict_cnt)
    );

    // Memory preload: word i holds 0x1000_0000 + i, except address 0x40.
    initial begin
        for (int i = 0; i < 256; i++) tb_mem[i] = 32'h1000_0000 + 32'(i);
        tb_mem[16] = 32'hDEAD_BEEF;
    end

    // Behavioural data memory with 1-cycle read latency.
    always @(posedge clk) begin
        if (mem_rd) mem_rdata <= tb_mem[mem_addr[9:2]];
        if (mem_wr) tb_mem[mem_addr[9:2]] <= mem_wd;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push_mem(input logic rd, input logic wr, input logic [31:0] addr, input logic [31:0] wd);
        mem_exp_t e;
        e.rd = rd; e.wr = wr; e.addr = addr; e.wd = wd;
        mem_q.push_back(e);
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
    endtask

    // Monitor: one line per observed transaction, compared against the queues.
    always @(negedge clk) begin
        mem_exp_t e;
        if (mem_rd === 1'b1 || mem_wr === 1'b1) begin
            $display("mem  rd=%0b wr=%0b addr=%h wd=%h", mem_rd, mem_wr, mem_addr, mem_wd);
            if (mem_q.size() == 0) check("mem_unexpected", 64'(1), 64'(0));
            else begin
                e = mem_q.pop_front();
                check("mem_strobe", 64'({mem_rd, mem_wr}), 64'({e.rd, e.wr}));
                check("mem_addr", 64'(mem_addr), 64'(e.addr));
                check("mem_wd", 64'(mem_wd), 64'(e.wd));
            end
        end
        if (cpu_rvalid === 1'b1) begin
            $display("cpu  rdata=%h", cpu_rdata);
            if (cpu_q.size() == 0) check("cpu_rvalid_unexpected", 64'(1), 64'(0));
            else check("cpu_rdata", 64'(cpu_rdata), 64'(cpu_q.pop_front()));
        end
        if (npu_rvalid === 1'b1) begin
            $display("npu  rdata=%h", npu_rdata);
            if (npu_q.size() == 0) check("npu_rvalid_unexpected", 64'(1), 64'(0));
            else check("npu_rdata", 64'(npu_rdata), 64'(npu_q.pop_front()));
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_cpu_rvalid", 64'(cpu_rvalid), 64'(0));
        check("rst_npu_rvalid", 64'(npu_rvalid), 64'(0));
        check("rst_cpu_rdata", 64'(cpu_rdata), 64'(0));
        check("rst_npu_rdata", 64'(npu_rdata), 64'(0));
        check("rst_err_both", 64'(err_both), 64'(0));
        check("rst_conflict_cnt", 64'(conflict_cnt), 64'(0));
        advance();

        // CPU-only read at 0x40
        cpu_rd = 1'b1; cpu_addr = 32'h40;
        push_mem(1'b1, 1'b0, 32'h40, 32'h0);
        cpu_q.push_back(32'hDEAD_BEEF);
        @(negedge clk);
        check("t1_cpu_stall", 64'(cpu_stall), 64'(0));
        check("t1_race_haz", 64'(race_haz), 64'(0));
        advance();
        cpu_rd = 1'b0; cpu_addr = '0;
        @(negedge clk);
        check("t1_cpu_rvalid", 64'(cpu_rvalid), 64'(1));
        advance();

        // Back-to-back reads with alternating owners
        cpu_rd = 1'b1; cpu_addr = 32'h0;
        push_mem(1'b1, 1'b0, 32'h0, 32'h0);
        cpu_q.push_back(32'h1000_0000);
        @(negedge clk);
        advance();
        cpu_rd = 1'b0; npu_rd = 1'b1; npu_addr = 32'h4;
        push_mem(1'b1, 1'b0, 32'h4, 32'h0);
        npu_q.push_back(32'h1000_0001);
        @(negedge clk);
        check("t2_c2_cpu_rvalid", 64'(cpu_rvalid), 64'(1));
        check("t2_c2_npu_rvalid", 64'(npu_rvalid), 64'(0));
        advance();
        npu_rd = 1'b0; npu_addr = '0;
        @(negedge clk);
        check("t2_c3_npu_rvalid", 64'(npu_rvalid), 64'(1));
        check("t2_c3_cpu_rvalid", 64'(cpu_rvalid), 64'(0));
        check("t2_c3_cpu_rdata_hold", 64'(cpu_rdata), 64'(32'h1000_0000));
        advance();

        // Both read continuously: NPU wins every 5th cycle
        cpu_rd = 1'b1; cpu_addr = 32'h100;
        npu_rd = 1'b1; npu_addr = 32'h200;
        for (int k = 1; k <= 10; k++) begin
            if (k % 5 == 0) begin
                push_mem(1'b1, 1'b0, 32'h200, 32'h0);
                npu_q.push_back(32'h1000_0080);
            end else begin
                push_mem(1'b1, 1'b0, 32'h100, 32'h0);
                cpu_q.push_back(32'h1000_0040);
            end
            @(negedge clk);
            check("t3_cpu_stall", 64'(cpu_stall), 64'(k % 5 == 0));
            check("t3_race_haz", 64'(race_haz), 64'(k % 5 != 0));
            check("t3_conflict_cnt", 64'(conflict_cnt), 64'(k - 1));
            advance();
        end
        cpu_rd = 1'b0; cpu_addr = '0; npu_rd = 1'b0; npu_addr = '0;
        @(negedge clk);
        check("t3_conflict_final", 64'(conflict_cnt), 64'(10));
        advance();

        // NPU rd and wr together -> write, sticky err_both
        npu_rd = 1'b1; npu_wr = 1'b1; npu_addr = 32'h10; npu_wd = 32'h33;
        push_mem(1'b0, 1'b1, 32'h10, 32'h33);
        @(negedge clk);
        check("t4_err_before", 64'(err_both), 64'(0));
        advance();
        npu_rd = 1'b0; npu_wr = 1'b0; npu_addr = '0; npu_wd = '0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("t4_err_sticky", 64'(err_both), 64'(1));
            advance();
        end

        // NPU read granted, reset on the return cycle
        npu_rd = 1'b1; npu_addr = 32'h4;
        push_mem(1'b1, 1'b0, 32'h4, 32'h0);
        @(negedge clk);
        advance();
        rst = 1'b1; npu_rd = 1'b0; npu_addr = '0; cpu_rd = 1'b1; cpu_addr = 32'h40;
        @(negedge clk);
        check("t5_npu_rvalid_in_rst", 64'(npu_rvalid), 64'(0));
        check("t5_cpu_stall_in_rst", 64'(cpu_stall), 64'(1));
        check("t5_mem_rd_in_rst", 64'(mem_rd), 64'(0));
        advance();
        rst = 1'b0; cpu_rd = 1'b0; cpu_addr = '0;
        @(negedge clk);
        check("t5_err_cleared", 64'(err_both), 64'(0));
        check("t5_conflict_cleared", 64'(conflict_cnt), 64'(0));
        check("t5_npu_rvalid", 64'(npu_rvalid), 64'(0));
        check("t5_cpu_rvalid", 64'(cpu_rvalid), 64'(0));
        check("t5_npu_rdata", 64'(npu_rdata), 64'(0));
        check("t5_cpu_rdata", 64'(cpu_rdata), 64'(0));
        advance();

        // MAX_STALL = 0: NPU wins every conflict
        z_cpu_wr = 1'b1; z_cpu_addr = 32'h8; z_cpu_wd = 32'h11;
        z_npu_wr = 1'b1; z_npu_addr = 32'hC; z_npu_wd = 32'h22;
        @(negedge clk);
        $display("dut0 wr addr=%h wd=%h cpu_stall=%0b", z_mem_addr, z_mem_wd, z_cpu_stall);
        check("t6_c1_mem_wr", 64'({z_mem_rd, z_mem_wr}), 64'(2'b01));
        check("t6_c1_mem_addr", 64'(z_mem_addr), 64'(32'hC));
        check("t6_c1_mem_wd", 64'(z_mem_wd), 64'(32'h22));
        check("t6_c1_cpu_stall", 64'(z_cpu_stall), 64'(1));
        check("t6_c1_race_haz", 64'(z_race_haz), 64'(0));
        advance();
        z_npu_wr = 1'b0; z_npu_addr = '0; z_npu_wd = '0;
        @(negedge clk);
        $display("dut0 wr addr=%h wd=%h cpu_stall=%0b", z_mem_addr, z_mem_wd, z_cpu_stall);
        check("t6_c2_mem_wr", 64'({z_mem_rd, z_mem_wr}), 64'(2'b01));
        check("t6_c2_mem_addr", 64'(z_mem_addr), 64'(32'h8));
        check("t6_c2_mem_wd", 64'(z_mem_wd), 64'(32'h11));
        check("t6_c2_cpu_stall", 64'(z_cpu_stall), 64'(0));
        advance();
        z_cpu_wr = 1'b0; z_cpu_wd = '0; z_cpu_rd = 1'b1; z_cpu_addr = 32'h20;
        z_npu_rd = 1'b1; z_npu_addr = 32'h24;
        @(negedge clk);
        $display("dut0 rd addr=%h cpu_stall=%0b", z_mem_addr, z_cpu_stall);
        check("t6_c3_mem_addr", 64'(z_mem_addr), 64'(32'h24));
        check("t6_c3_cpu_stall", 64'(z_cpu_stall), 64'(1));
        check("t6_c3_race_haz", 64'(z_race_haz), 64'(0));
        advance();
        z_cpu_rd = 1'b0; z_cpu_addr = '0; z_npu_rd = 1'b0; z_npu_addr = '0;

        // Drain and confirm every expected transaction was observed
        repeat (3) advance();
        check("end_mem_q_empty", 64'(mem_q.size()), 64'(0));
        check("end_cpu_q_empty", 64'(cpu_q.size()), 64'(0));
        check("end_npu_q_empty", 64'(npu_q.size()), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
